gcn_core: RTL and testbench
===========================

Name: gcn_core

Overview:
- Single-layer graph-convolution inference engine for a 6-node graph.
- Fetches the weight matrix and the node feature matrix from an external combinational memory and computes the product FM×WM.
- Aggregates the product rows over the edges of a COO adjacency list, then reports the arg-max class index per node.
- Sits between the shared feature/weight memory, the COO edge store and the result consumer.

Parameters:
- FEATURE_COLS, 96, features per node (equals WEIGHT_ROWS).
- WEIGHT_ROWS, 96, elements per weight column; also the width of the data_in vector.
- FEATURE_ROWS, 6, number of nodes.
- WEIGHT_COLS, 3, number of output classes.
- FEATURE_WIDTH, 5, unsigned feature element width.
- WEIGHT_WIDTH, 5, unsigned weight element width.
- DOT_PROD_WIDTH, 16, product and aggregate width.
- ADDRESS_WIDTH, 13, read address width.
- NUM_OF_NODES, 6, graph nodes.
- COO_NUM_OF_COLS, 6, number of edges.
- COO_NUM_OF_ROWS, 2, endpoints per edge.
- COO_BW, $clog2(COO_NUM_OF_COLS), node index and COO address width.
- MAX_ADDRESS_WIDTH, 2, arg-max index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; computation begins on the first rising edge where start=1 in IDLE.
- data_in  in  WEIGHT_ROWS×WEIGHT_WIDTH (unpacked array)  memory word at read_address.
- coo_in  in  2×COO_BW  edge at coo_address; bits [2*COO_BW-1:COO_BW] are endpoint A, bits [COO_BW-1:0] are endpoint B.
- coo_address  out  COO_BW  edge index 0..COO_NUM_OF_COLS-1.
- read_address  out  ADDRESS_WIDTH  weight column c at address c; feature row r at address 0x200+r.
- enable_read  out  1  read_address is valid.
- done  out  1  results valid.
- max_addi_answer  out  FEATURE_ROWS×MAX_ADDRESS_WIDTH (unpacked array)  arg-max class per node.

Behaviour:
- Reset (reset=0, async): FSM→IDLE; all outputs 0, accumulators 0.
- Memory is combinational. The DUT drives address and enable in cycle N and samples data_in or coo_in at the rising edge ending cycle N.
- FSM sequence:
  - IDLE: wait for start.
  - LOAD_W: 3 cycles; addresses 0,1,2; latch weight columns.
  - FEAT: per row r=0..5:
    - 1 read cycle at address 0x200+r.
    - 3 MAC cycles, one column each; FW[r][c] = Σk F[r][k]·W[c][k].
    - Each product is 10-bit unsigned; the sum is truncated to 16 bits (mod 2^16).
  - AGG: 6 cycles; coo_address=e reads edge (a,b).
    - Node indices are 1-based: value v maps to node v-1.
    - AG[a-1] += FW[b-1] and AG[b-1] += FW[a-1] (undirected), all additions mod 2^16.
    - AG starts at 0.
  - ARGMAX: 1 cycle; per node, the index of the largest unsigned AG column.
  - DONE: done=1 and held; max_addi_answer stable until reset.
- Edge-case rules:
  - Arg-max ties resolve to the lowest index.
  - enable_read=0 outside LOAD_W and FEAT reads; read_address holds its last value.
  - COO value 0 or greater than NUM_OF_NODES: edge ignored.
  - Self-edge (a==b): FW[a-1] added once.
  - start held high after done: no restart. A restart needs reset.
  - Reset mid-operation aborts immediately, clears state and returns to IDLE.
- Total latency start→done = 3+24+6+1+1 = 35 cycles.

Optional Feature:
- SELF_LOOP_EN defined: AG[i] is initialised to FW[i] before the AGG phase (A+I aggregation); adds 1 cycle to latency, 36 total.
- SELF_LOOP_EN undefined: AG initialised to 0.

Decomposition:
- Package gcn_pkg holds:
  - width and size localparams;
  - FEATURE_BASE_ADDR = 13'h200;
  - FSM state enum;
  - typedefs for the weight column array, FW/AG matrices and the arg-max array.
- Sub-module gcn_dot_product: combinational 96-element unsigned MAC with a 16-bit truncated result, reused across FEAT cycles.

Test Plan:
- All features=1, weight column c elements=c+1 → FW row = 96,192,288. With edges (1,2),(2,3),(3,4),(4,5),(5,6),(6,1), each node has AG = 2×FW. Expect all answers=2, done at cycle 35.
- Weights all 0 → all AG=0; tie rule gives every answer=0.
- Column 0 weights=31, features=31 → FW[r][0] = 96·961 mod 65536 = 26720. Column 1 weights=1, features=31 → FW[r][1] = 2976. Column 2 weights=0. Expect answer=0 for nodes with edges (truncation check).
- Edge list with value 0 entries plus one (2,2) self-edge → ignored edges add nothing; node 2 gets FW[1] once; nodes with no edges answer 0.
- Reset pulsed low during the FEAT phase → done=0 and outputs 0 immediately. A new start yields results identical to a clean run.
- Protocol checks:
  - Read addresses in order are 0,1,2,0x200..0x205 with enable_read=1 only in those cycles.
  - coo_address runs 0..5.
  - done stays 1 with stable outputs for 100 cycles after completion.

Source files
------------

// File: rtl/gcn_pkg.sv
// gcn_pkg: sizes, memory map, FSM states and matrix typedefs for gcn_core.
// Optional feature macro used by the core: SELF_LOOP_EN (A+I aggregation).
package gcn_pkg;
  localparam int FEATURE_COLS      = 96;
  localparam int WEIGHT_ROWS       = 96;
  localparam int FEATURE_ROWS      = 6;
  localparam int WEIGHT_COLS       = 3;
  localparam int FEATURE_WIDTH     = 5;
  localparam int WEIGHT_WIDTH      = 5;
  localparam int DOT_PROD_WIDTH    = 16;
  localparam int ADDRESS_WIDTH     = 13;
  localparam int NUM_OF_NODES      = 6;
  localparam int COO_NUM_OF_COLS   = 6;
  localparam int COO_NUM_OF_ROWS   = 2;
  localparam int COO_BW            = $clog2(COO_NUM_OF_COLS);
  localparam int MAX_ADDRESS_WIDTH = 2;

  localparam logic [ADDRESS_WIDTH-1:0] FEATURE_BASE_ADDR = 13'h200;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_FEAT   = 3'd2,
    S_INIT   = 3'd3,
    S_AGG    = 3'd4,
    S_ARGMAX = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  typedef logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0]    wvec_t;
  typedef logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0]  fvec_t;
  typedef wvec_t [WEIGHT_COLS-1:0]                     wmat_t;
  typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  row_t;
  typedef row_t [FEATURE_ROWS-1:0]                     mat_t;
  typedef logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0] amax_t;

  // Index of the largest unsigned column; strict '>' keeps ties on the lowest index.
  function automatic logic [MAX_ADDRESS_WIDTH-1:0] argmax(input row_t r);
    logic [DOT_PROD_WIDTH-1:0]    best;
    logic [MAX_ADDRESS_WIDTH-1:0] idx;
    best = r[0];
    idx  = '0;
    for (int c = 1; c < WEIGHT_COLS; c++) begin
      if (r[c] > best) begin
        best = r[c];
        idx  = MAX_ADDRESS_WIDTH'(c);
      end
    end
    return idx;
  endfunction
endpackage

// File: rtl/gcn_dot_product.sv
// gcn_dot_product: combinational 96-element unsigned MAC, result mod 2^16.
module gcn_dot_product
  import gcn_pkg::*;
(
  input  fvec_t                     feat,
  input  wvec_t                     wt,
  output logic [DOT_PROD_WIDTH-1:0] dot
);
  localparam int PW = FEATURE_WIDTH + WEIGHT_WIDTH;

  logic [WEIGHT_ROWS-1:0][PW-1:0] prod;

  genvar k;
  generate
    for (k = 0; k < WEIGHT_ROWS; k++) begin : g_lane
      assign prod[k] = PW'(feat[k]) * PW'(wt[k]);
    end
  endgenerate

  // Sum lane products; the accumulator width itself performs the truncation.
  always_comb begin
    dot = '0;
    for (int i = 0; i < WEIGHT_ROWS; i++) dot = dot + DOT_PROD_WIDTH'(prod[i]);
  end
endmodule

// File: rtl/gcn_core.sv
// gcn_core: single-layer GCN on a 6-node graph. Loads 3 weight columns, computes
// FW = F x W row by row, aggregates FW over a COO edge list, reports per-node arg-max.
// Define SELF_LOOP_EN to seed the aggregate with FW (A+I), adding one cycle.
module gcn_core
  import gcn_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [WEIGHT_WIDTH-1:0]           data_in [WEIGHT_ROWS],
  input  logic [COO_NUM_OF_ROWS*COO_BW-1:0] coo_in,
  output logic [COO_BW-1:0]                 coo_address,
  output logic [ADDRESS_WIDTH-1:0]          read_address,
  output logic                              enable_read,
  output logic                              done,
  output logic [MAX_ADDRESS_WIDTH-1:0]      max_addi_answer [FEATURE_ROWS]
);
  state_t                    state;
  logic [COO_BW-1:0]         cnt;
  logic [COO_BW-1:0]         row;
  logic [1:0]                sub;      // 0: feature read, 1..3: MAC column sub-1
  logic [1:0]                mac_col;
  wmat_t                     wcol;
  fvec_t                     frow;
  mat_t                      fw;
  mat_t                      ag;
  amax_t                     am;
  wvec_t                     din_p;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [ADDRESS_WIDTH-1:0]  addr_cur;
  logic [DOT_PROD_WIDTH-1:0] dot;
  logic [COO_BW-1:0]         ea, eb, ia, ib;
  logic                      edge_ok;

  // Pack the memory word and expose the latched arg-max results.
  always_comb begin
    for (int k = 0; k < WEIGHT_ROWS; k++) din_p[k] = data_in[k];
    for (int i = 0; i < FEATURE_ROWS; i++) max_addi_answer[i] = am[i];
  end

  // Memory/COO addressing; read_address falls back to the last issued address.
  always_comb begin
    enable_read  = (state == S_LOAD_W) || (state == S_FEAT && sub == 2'd0);
    addr_cur     = (state == S_LOAD_W) ? ADDRESS_WIDTH'(cnt)
                                       : FEATURE_BASE_ADDR + ADDRESS_WIDTH'(row);
    read_address = enable_read ? addr_cur : addr_q;
    coo_address  = (state == S_AGG) ? cnt : '0;
  end

  // Edge decode: 1-based node ids, any out-of-range endpoint drops the edge.
  always_comb begin
    ea      = coo_in[2*COO_BW-1:COO_BW];
    eb      = coo_in[COO_BW-1:0];
    ia      = ea - COO_BW'(1);
    ib      = eb - COO_BW'(1);
    edge_ok = (ea != '0) && (eb != '0) &&
              (ea <= COO_BW'(NUM_OF_NODES)) && (eb <= COO_BW'(NUM_OF_NODES));
    mac_col = (sub == 2'd0) ? 2'd0 : sub - 2'd1;
  end

  gcn_dot_product u_dot (
    .feat (frow),
    .wt   (wcol[mac_col]),
    .dot  (dot)
  );

  // Remember the last read address so it holds while enable_read is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           addr_q <= '0;
    else if (enable_read) addr_q <= addr_cur;
  end

  // Main sequencer: LOAD_W -> FEAT -> [INIT] -> AGG -> ARGMAX -> DONE (sticky).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      row   <= '0;
      sub   <= '0;
      wcol  <= '0;
      frow  <= '0;
      fw    <= '0;
      ag    <= '0;
      am    <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_LOAD_W;
          cnt   <= '0;
          row   <= '0;
          sub   <= '0;
          fw    <= '0;
          ag    <= '0;
        end
        S_LOAD_W: begin
          wcol[cnt[1:0]] <= din_p;
          if (cnt == COO_BW'(WEIGHT_COLS - 1)) begin
            cnt   <= '0;
            state <= S_FEAT;
          end else cnt <= cnt + COO_BW'(1);
        end
        S_FEAT: begin
          if (sub == 2'd0) frow <= fvec_t'(din_p);
          else             fw[row][mac_col] <= dot;
          if (sub == 2'd3) begin
            sub <= '0;
            if (row == COO_BW'(FEATURE_ROWS - 1)) begin
              row <= '0;
              cnt <= '0;
`ifdef SELF_LOOP_EN
              state <= S_INIT;
`else
              state <= S_AGG;
`endif
            end else row <= row + COO_BW'(1);
          end else sub <= sub + 2'd1;
        end
`ifdef SELF_LOOP_EN
        S_INIT: begin
          ag    <= fw;
          state <= S_AGG;
        end
`endif
        S_AGG: begin
          if (edge_ok) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
              if (ia == ib) begin
                ag[ia][c] <= ag[ia][c] + fw[ia][c];
              end else begin
                ag[ia][c] <= ag[ia][c] + fw[ib][c];
                ag[ib][c] <= ag[ib][c] + fw[ia][c];
              end
            end
          end
          if (cnt == COO_BW'(COO_NUM_OF_COLS - 1)) begin
            cnt   <= '0;
            state <= S_ARGMAX;
          end else cnt <= cnt + COO_BW'(1);
        end
        S_ARGMAX: begin
          for (int i = 0; i < FEATURE_ROWS; i++) am[i] <= argmax(ag[i]);
          state <= S_DONE;
        end
        S_DONE: done <= 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcn_core.sv
// tb_gcn_core: directed + random runs of gcn_core against an arithmetic model
// (FW = F x W mod 2^16, undirected edge aggregation, lowest-index arg-max).
module tb_gcn_core;
  import gcn_pkg::*;

`ifdef SELF_LOOP_EN
  localparam int SL = 1;
`else
  localparam int SL = 0;
`endif
  localparam int LAT  = 35 + SL;
  localparam int AGG0 = 27 + SL;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  data_in [96];
  logic [5:0]  coo_in;
  logic [2:0]  coo_address;
  logic [12:0] read_address;
  logic        enable_read;
  logic        done;
  logic [1:0]  max_addi_answer [6];

  int unsigned W [3][96];
  int unsigned F [6][96];
  int unsigned EA [6];
  int unsigned EB [6];
  int          exp_ans [6];
  int          total = 0;
  int          bad = 0;

  gcn_core dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .data_in         (data_in),
    .coo_in          (coo_in),
    .coo_address     (coo_address),
    .read_address    (read_address),
    .enable_read     (enable_read),
    .done            (done),
    .max_addi_answer (max_addi_answer)
  );

  always #5 clk = ~clk;

  // Combinational memory: weight column c at c, feature row r at 0x200+r.
  always_comb begin
    for (int k = 0; k < 96; k++) begin
      data_in[k] = 5'd0;
      if (read_address < 13'd3)
        data_in[k] = 5'(W[read_address[1:0]][k]);
      else if (read_address >= 13'h200 && read_address < 13'h206)
        data_in[k] = 5'(F[read_address[2:0]][k]);
    end
  end

  always_comb begin
    coo_in = 6'd0;
    if (coo_address < 3'd6) coo_in = {3'(EA[coo_address]), 3'(EB[coo_address])};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model();
    int fwm [6][3];
    int agm [6][3];
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 3; c++) begin
        longint s = 0;
        for (int k = 0; k < 96; k++) s += longint'(F[r][k]) * longint'(W[c][k]);
        fwm[r][c] = int'(s % 65536);
        agm[r][c] = (SL == 1) ? fwm[r][c] : 0;
      end
    for (int e = 0; e < 6; e++) begin
      int a = int'(EA[e]);
      int b = int'(EB[e]);
      if (a < 1 || b < 1 || a > 6 || b > 6) continue;
      for (int c = 0; c < 3; c++) begin
        if (a == b) agm[a-1][c] = (agm[a-1][c] + fwm[a-1][c]) % 65536;
        else begin
          agm[a-1][c] = (agm[a-1][c] + fwm[b-1][c]) % 65536;
          agm[b-1][c] = (agm[b-1][c] + fwm[a-1][c]) % 65536;
        end
      end
    end
    for (int n = 0; n < 6; n++) begin
      exp_ans[n] = 0;
      for (int c = 1; c < 3; c++) if (agm[n][c] > agm[n][exp_ans[n]]) exp_ans[n] = c;
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic ring_edges();
    for (int e = 0; e < 6; e++) begin
      EA[e] = e + 1;
      EB[e] = (e + 1) % 6 + 1;
    end
  endtask

  task automatic rand_data();
    for (int r = 0; r < 6; r++) for (int k = 0; k < 96; k++) F[r][k] = $urandom_range(0, 31);
    for (int c = 0; c < 3; c++) for (int k = 0; k < 96; k++) W[c][k] = $urandom_range(0, 31);
  endtask

  // One full computation from IDLE: timeline protocol, latency, answers, hold.
  task automatic run(input string tag);
    int lat = -1;
    int perr = 0;
    int cerr = 0;
    int herr = 0;
    logic [12:0] last = 13'd0;
    model();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < LAT + 5 && lat < 0; i++) begin
      logic en;
      @(negedge clk);
      en = (i < 3) || (i < 27 && (i - 3) % 4 == 0);
      if (en) last = (i < 3) ? 13'(i) : 13'(32'h200 + (i - 3) / 4);
      if (enable_read !== en || read_address !== last) perr++;
      if (i >= AGG0 && i < AGG0 + 6 && coo_address !== 3'(i - AGG0)) cerr++;
      if (done === 1'b1) lat = i;
    end
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_read_protocol_errs"}, perr, 0);
    chk({tag, "_coo_protocol_errs"}, cerr, 0);
    for (int n = 0; n < 6; n++)
      chk($sformatf("%s_ans%0d", tag, n), 32'(max_addi_answer[n]), exp_ans[n]);
    repeat (100) begin
      @(negedge clk);
      if (done !== 1'b1) herr++;
      for (int n = 0; n < 6; n++) if (max_addi_answer[n] !== 2'(exp_ans[n])) herr++;
    end
    chk({tag, "_hold_errs"}, herr, 0);
  endtask

  initial begin
    for (int e = 0; e < 6; e++) begin EA[e] = 0; EB[e] = 0; end
    do_reset();
    chk("rst_done", done, 0);
    chk("rst_en", enable_read, 0);
    chk("rst_addr", read_address, 0);
    chk("rst_coo", coo_address, 0);
    chk("rst_ans0", 32'(max_addi_answer[0]), 0);

    // Case 1: unit features, weight column c = c+1, ring graph -> all class 2.
    for (int r = 0; r < 6; r++) for (int k = 0; k < 96; k++) F[r][k] = 1;
    for (int c = 0; c < 3; c++) for (int k = 0; k < 96; k++) W[c][k] = c + 1;
    ring_edges();
    run("ring");
    for (int n = 0; n < 6; n++) chk($sformatf("ring_is2_%0d", n), 32'(max_addi_answer[n]), 2);

    // Reset mid-FEAT clears outputs immediately.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    repeat (11) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_done", done, 0);
    chk("midrst_en", enable_read, 0);
    chk("midrst_addr", read_address, 0);
    for (int n = 0; n < 6; n++) chk($sformatf("midrst_ans%0d", n), 32'(max_addi_answer[n]), 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rand_data();
    ring_edges();
    run("after_midrst");

    // Case 2: zero weights -> ties everywhere -> class 0.
    do_reset();
    for (int c = 0; c < 3; c++) for (int k = 0; k < 96; k++) W[c][k] = 0;
    run("zero_w");

    // Case 3: truncation, FW row = 26720, 2976, 0.
    do_reset();
    for (int r = 0; r < 6; r++) for (int k = 0; k < 96; k++) F[r][k] = 31;
    for (int k = 0; k < 96; k++) begin W[0][k] = 31; W[1][k] = 1; W[2][k] = 0; end
    run("trunc");

    // Case 4: invalid endpoints and a self-edge.
    do_reset();
    rand_data();
    EA = '{0, 2, 5, 7, 1, 0};
    EB = '{3, 2, 0, 4, 3, 0};
    run("bad_edges");

    // Random graphs and data, endpoints drawn from 0..7.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      rand_data();
      for (int e = 0; e < 6; e++) begin
        EA[e] = $urandom_range(0, 7);
        EB[e] = $urandom_range(0, 7);
      end
      run($sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
